// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: mul/div sequencing state, op encodings,
// default unit latencies and the register-match helper used by hazard detection.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   localparam logic MULDIV_OP_MUL = 1'b0;
   localparam logic MULDIV_OP_DIV = 1'b1;

   localparam int unsigned DEF_MUL_CYCLES = 4;
   localparam int unsigned DEF_DIV_CYCLES = 32;

   // $0 is hardwired, so it never creates a dependency
   function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: decode/execute/memory hazard
// inputs in, stall/flush and HI/LO controls out.
interface hazard_ctrl_if;
   logic [4:0] RsD, RtD, WriteRegE, WriteRegM;
   logic       RegWriteE, MemtoRegE, MemtoRegM;
   logic       BranchD, JumpRegD, PCSrcD;
   logic       MulDivD, HiLoReadD, MulDivStartE, MulDivOpE;
   logic       StallF, StallD, FlushD, FlushE;
   logic       MulDivBusy, HiLoWriteEn;

   modport master (
      output RsD, RtD, WriteRegE, WriteRegM, RegWriteE, MemtoRegE, MemtoRegM,
             BranchD, JumpRegD, PCSrcD, MulDivD, HiLoReadD, MulDivStartE, MulDivOpE,
      input  StallF, StallD, FlushD, FlushE, MulDivBusy, HiLoWriteEn
   );

   modport slave (
      input  RsD, RtD, WriteRegE, WriteRegM, RegWriteE, MemtoRegE, MemtoRegM,
             BranchD, JumpRegD, PCSrcD, MulDivD, HiLoReadD, MulDivStartE, MulDivOpE,
      output StallF, StallD, FlushD, FlushE, MulDivBusy, HiLoWriteEn
   );
endinterface

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Multi-cycle mul/div sequencer: tracks the unit's latency from issue in E and
// pulses the HI/LO commit when the result is ready.
module muldiv_seq
   import mips_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
   parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic startE,
   input  logic opE,
   output logic busy,
   output logic hiLoWriteEn,
   output logic busy_or_starting
);

   localparam int unsigned CW = $clog2(DIV_CYCLES);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);

   muldiv_state_t state;
   logic [CW-1:0] cnt;
   logic          busyR;
   logic          doneR;

   // busyR/doneR are the registered decode of the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busyR <= 1'b0;
         doneR <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (startE) begin
                  state <= BUSY;
                  cnt   <= (opE == MULDIV_OP_DIV) ? DIV_LOAD : MUL_LOAD;
                  busyR <= 1'b1;
                  doneR <= 1'b0;
               end else begin
                  state <= IDLE;
                  busyR <= 1'b0;
                  doneR <= 1'b0;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state <= DONE;
                  busyR <= 1'b1;
                  doneR <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busyR <= 1'b0;
               doneR <= 1'b0;
            end
         endcase
      end
   end

   assign busy             = busyR & ~rst;
   assign hiLoWriteEn      = doneR & ~rst;
   assign busy_or_starting = (state == BUSY) | ((state == IDLE) & startE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, decode-resolved branch/jr and mul/div
// hazards combined into the F/D/E stall and flush controls.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
   parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);

   logic rsMatchE, rtMatchE, rsMatchM, rtMatchM;
   logic lwStall, brStall, jrStall, mdStall, stall;
   logic busyOrStarting;

   assign rsMatchE = regMatch(hz.WriteRegE, hz.RsD);
   assign rtMatchE = regMatch(hz.WriteRegE, hz.RtD);
   assign rsMatchM = regMatch(hz.WriteRegM, hz.RsD);
   assign rtMatchM = regMatch(hz.WriteRegM, hz.RtD);

   assign lwStall = hz.MemtoRegE & hz.RegWriteE & (rsMatchE | rtMatchE);
   assign brStall = hz.BranchD & ((hz.RegWriteE & (rsMatchE | rtMatchE)) |
                                  (hz.MemtoRegM & (rsMatchM | rtMatchM)));
   assign jrStall = hz.JumpRegD & ((hz.RegWriteE & rsMatchE) | (hz.MemtoRegM & rsMatchM));
   assign mdStall = (hz.MulDivD | hz.HiLoReadD) & busyOrStarting;

   assign stall = (lwStall | brStall | jrStall | mdStall) & ~rst;

   assign hz.StallF = stall;
   assign hz.StallD = stall;
   assign hz.FlushE = stall;
   assign hz.FlushD = hz.PCSrcD & ~stall & ~rst;

   muldiv_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_muldiv_seq (
      .clk              (clk),
      .rst              (rst),
      .startE           (hz.MulDivStartE),
      .opE              (hz.MulDivOpE),
      .busy             (hz.MulDivBusy),
      .hiLoWriteEn      (hz.HiLoWriteEn),
      .busy_or_starting (busyOrStarting)
   );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage MIPS core.
- Works alongside the bypass logic in the same pipeline.
- Generates the stall and flush controls for the F/D/E pipeline registers. It covers:
  - load-use hazards;
  - branch and `jr` hazards resolved in decode;
  - structural and data hazards of the multi-cycle multiply/divide unit, which it sequences with an internal FSM and latency counter.
- Sits between the decode/execute pipeline registers and the mul/div unit, and drives its HI/LO write enable.

## Interface
Parameters:
- `MUL_CYCLES`, 4: mult/multu latency from issue in E to HI/LO write; must be ≥2.
- `DIV_CYCLES`, 32: div/divu latency, same definition; must be ≥ `MUL_CYCLES`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `RsD`, `RtD` in 5: decode-stage source registers.
- `WriteRegE`, `WriteRegM` in 5: destination registers in E and M.
- `RegWriteE` in 1: E-stage instruction writes the register file.
- `MemtoRegE`, `MemtoRegM` in 1: instruction in E/M is a load.
- `BranchD` in 1: beq/bne in decode (compares Rs and Rt).
- `JumpRegD` in 1: jr/jalr in decode (uses Rs only).
- `PCSrcD` in 1: branch/jump taken, resolved in decode.
- `MulDivD` in 1: mult/div-class instruction in decode.
- `HiLoReadD` in 1: mfhi/mflo in decode.
- `MulDivStartE` in 1: mult/div-class instruction in E this cycle.
- `MulDivOpE` in 1: 0 = multiply, 1 = divide.
- `StallF`, `StallD` out 1: hold the PC and the F/D register.
- `FlushD`, `FlushE` out 1: clear the F/D and D/E registers.
- `MulDivBusy` out 1: the FSM is not IDLE.
- `HiLoWriteEn` out 1: one-cycle pulse that commits the mul/div result to HI/LO.

## Operation
A register "matches" only if it is nonzero and equal to the register it is compared with.

Hazard terms:
- **lwstall**: `MemtoRegE & RegWriteE` and `WriteRegE` matches `RsD` or `RtD`.
- **brstall**: `BranchD` and either:
  - `RegWriteE` and `WriteRegE` matches `RsD` or `RtD`; or
  - `MemtoRegM` and `WriteRegM` matches `RsD` or `RtD`.
- **jrstall**: same as brstall, but with `JumpRegD` and comparing `RsD` only.
- **mdstall**: `(MulDivD | HiLoReadD)` and either the state is BUSY, or the state is IDLE with `MulDivStartE`.

Outputs:
- `StallF = StallD = lwstall | brstall | jrstall | mdstall`.
- `FlushE = StallD`, which inserts a bubble.
- `FlushD = PCSrcD & ~StallD`.

Mul/div FSM states are IDLE, BUSY and DONE:
- **IDLE**:
  - If `MulDivStartE`: load the counter with (`MulDivOpE ? DIV_CYCLES : MUL_CYCLES`) − 2 and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**: if the counter is 0, go to DONE; otherwise decrement the counter.
- **DONE**:
  - `HiLoWriteEn` = 1.
  - If `MulDivStartE`: behave exactly as IDLE does on a start.
  - Otherwise go to IDLE.
- `MulDivStartE` while in BUSY is ignored. This cannot occur, because mdstall blocks it.
- Counter width is `$clog2(DIV_CYCLES)`. It never wraps.

Reset:
- While `rst` = 1, all outputs are forced to 0 combinationally.
- At the clock edge with `rst` = 1, the state becomes IDLE and the counter becomes 0.
- Reset in the middle of a multiply/divide aborts it; no `HiLoWriteEn` is produced.

## Timing
- Stall and flush outputs are purely combinational in the same cycle. No registered latency.
- `MulDivBusy` and `HiLoWriteEn` are decoded from registered state.
- A start seen in E in cycle t0 gives:
  - BUSY in cycles t0+1 … t0+LAT−1;
  - DONE (`HiLoWriteEn` = 1) in cycle t0+LAT.
  - Example: multiply, `MUL_CYCLES` = 4, gives `HiLoWriteEn` at t0+4.
- mdstall is low in DONE. A held mfhi enters E in cycle t0+LAT+1 and reads the committed HI/LO.
- Simultaneous stall sources OR together. If `PCSrcD` and a stall occur together, the stall wins and `FlushD` = 0.
- `MulDivBusy` = 1 in BUSY and DONE.

## Structure
- Shared package `mips_pkg` holds:
  - the `muldiv_state_t` enum (IDLE/BUSY/DONE);
  - the `MULDIV_OP_MUL` / `MULDIV_OP_DIV` encodings;
  - the default `MUL_CYCLES` / `DIV_CYCLES` constants.
- One sub-module, `muldiv_seq`, holds the FSM, counter, `MulDivBusy` and `HiLoWriteEn`, and exports a `busy_or_starting` flag.
- The top level holds the comparators and the stall/flush equations.

## Test plan
- Load-use hazard: lw $8 in E (`MemtoRegE` = 1, `WriteRegE` = 8) with `RsD` = 8.
  - Required: `StallF` = `StallD` = `FlushE` = 1 that cycle, and 0 the next cycle.
  - Repeat with `WriteRegE` = 0: no stall.
- Branch hazards:
  - beq with `RtD` = 9 while `RegWriteE` = 1 and `WriteRegE` = 9: stall.
  - Next cycle, lw $9 in M (`MemtoRegM` = 1): stall again.
  - When the hazard is clear and `PCSrcD` = 1: `FlushD` = 1.
- Multiply latency: `MulDivStartE` = 1 with `MulDivOpE` = 0 at t0, and mfhi held in D.
  - Required: `StallD` high in t0 … t0+3.
  - Required: `HiLoWriteEn` pulses only at t0+4.
  - Required: `StallD` low at t0+4.
- Divide latency: `MulDivOpE` = 1 gives `HiLoWriteEn` at exactly t0+32 and `MulDivBusy` high in t0+1 … t0+32. A second mult held in D is released at t0+32.
- Reset mid-divide: assert `rst` at t0+10.
  - Required: all outputs 0, state IDLE next cycle, no `HiLoWriteEn` afterwards.
- Priority: lwstall together with `PCSrcD` = 1.
  - Required: `FlushD` = 0, `FlushE` = 1.
